// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and an
// optional first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THR     = FIFO_DEPTH - 1,
  parameter int AE_THR     = 1,
  parameter bit FWFT       = 1'b0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_ok, rd_ok;

  // A full FIFO still takes a write when the same cycle pops a word.
  assign rd_ok = rd_en && !empty_q;
  assign wr_ok = wr_en && (!full_q || rd_en);

  // Next-state for pointers, occupancy, flags and error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
    // Flags come from count_d so they always agree with count.
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(FIFO_DEPTH));
    ae_d    = (count_d <= CW'(AE_THR));
    af_d    = (count_d >= CW'(AF_THR));
    ovf_d   = wr_en && !wr_ok;
    unf_d   = rd_en && !rd_ok;
  end

  // Control state; requests seen during reset are dropped silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; contents persist across reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head of queue is shown directly; meaningless while empty.
      assign data_out = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q, dout_d;

      // Registered read port holds its value unless a read is accepted.
      always_comb begin
        dout_d = dout_q;
        if (rd_ok) dout_d = mem_q[rd_ptr_q];
      end

      // Read data register, cleared by reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: instance A is DEPTH=8 registered read (AF=6, AE=1),
// instance B is DEPTH=5 first-word-fall-through.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       wr_a = 0, rd_a = 0;
  logic [7:0] din_a = '0, dout_a;
  logic       empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
  logic [3:0] cnt_a;

  logic       wr_b = 0, rd_b = 0;
  logic [7:0] din_b = '0, dout_b;
  logic       empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
  logic [2:0] cnt_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .AF_THR(6), .AE_THR(1), .FWFT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_a), .data_in(din_a), .rd_en(rd_a), .data_out(dout_a),
    .empty(empty_a), .full(full_a), .almost_empty(ae_a), .almost_full(af_a),
    .count(cnt_a), .overflow(ovf_a), .underflow(unf_a));

  sync_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_b), .data_in(din_b), .rd_en(rd_b), .data_out(dout_b),
    .empty(empty_b), .full(full_b), .almost_empty(ae_b), .almost_full(af_b),
    .count(cnt_b), .overflow(ovf_b), .underflow(unf_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++; if (cnt_a !== 4'd0)   begin miscompares++; $display("FAIL reset_count got %0d want 0", cnt_a); end
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty_a); end
    vectors++; if (ae_a !== 1'b1)    begin miscompares++; $display("FAIL reset_ae got %b want 1", ae_a); end
    vectors++; if (full_a !== 1'b0)  begin miscompares++; $display("FAIL reset_full got %b want 0", full_a); end
    vectors++; if (af_a !== 1'b0)    begin miscompares++; $display("FAIL reset_af got %b want 0", af_a); end
    vectors++; if (dout_a !== 8'h00) begin miscompares++; $display("FAIL reset_dout got %h want 00", dout_a); end
    vectors++; if (empty_b !== 1'b1 || cnt_b !== 3'd0) begin miscompares++; $display("FAIL reset_b got empty=%b count=%0d want 1/0", empty_b, cnt_b); end
    rst = 1'b0;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      wr_a = 1'b1; din_a = 8'(i);
      step();
      vectors++; if (cnt_a !== 4'(i)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, cnt_a, i); end
      vectors++; if (ae_a !== (i <= 1)) begin miscompares++; $display("FAIL fill_ae[%0d] got %b want %b", i, ae_a, (i <= 1)); end
      vectors++; if (af_a !== (i >= 6)) begin miscompares++; $display("FAIL fill_af[%0d] got %b want %b", i, af_a, (i >= 6)); end
      vectors++; if (full_a !== (i == 8)) begin miscompares++; $display("FAIL fill_full[%0d] got %b want %b", i, full_a, (i == 8)); end
      vectors++; if (empty_a !== 1'b0) begin miscompares++; $display("FAIL fill_empty[%0d] got %b want 0", i, empty_a); end
    end
    din_a = 8'h09;
    step();
    wr_a = 1'b0;
    vectors++; if (ovf_a !== 1'b1)  begin miscompares++; $display("FAIL ovf_pulse got %b want 1", ovf_a); end
    vectors++; if (cnt_a !== 4'd8)  begin miscompares++; $display("FAIL ovf_count got %0d want 8", cnt_a); end
    step();
    vectors++; if (ovf_a !== 1'b0)  begin miscompares++; $display("FAIL ovf_clear got %b want 0", ovf_a); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 8; i++) begin
      rd_a = 1'b1;
      step();
      vectors++; if (dout_a !== 8'(i)) begin miscompares++; $display("FAIL drain_data[%0d] got %h want %h", i, dout_a, 8'(i)); end
      vectors++; if (cnt_a !== 4'(8 - i)) begin miscompares++; $display("FAIL drain_count[%0d] got %0d want %0d", i, cnt_a, 8 - i); end
    end
    step();
    rd_a = 1'b0;
    vectors++; if (unf_a !== 1'b1)   begin miscompares++; $display("FAIL unf_pulse got %b want 1", unf_a); end
    vectors++; if (dout_a !== 8'h08) begin miscompares++; $display("FAIL unf_dout got %h want 08", dout_a); end
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL unf_empty got %b want 1", empty_a); end
    step();
    vectors++; if (unf_a !== 1'b0)   begin miscompares++; $display("FAIL unf_clear got %b want 0", unf_a); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_seq [8];
    for (int i = 0; i < 8; i++) begin
      wr_a = 1'b1; din_a = 8'h11 + 8'(i);
      step();
    end
    rd_a = 1'b1; din_a = 8'hAA;
    step();
    wr_a = 1'b0;
    vectors++; if (cnt_a !== 4'd8)   begin miscompares++; $display("FAIL full_rw_count got %0d want 8", cnt_a); end
    vectors++; if (ovf_a !== 1'b0)   begin miscompares++; $display("FAIL full_rw_ovf got %b want 0", ovf_a); end
    vectors++; if (full_a !== 1'b1)  begin miscompares++; $display("FAIL full_rw_full got %b want 1", full_a); end
    vectors++; if (dout_a !== 8'h11) begin miscompares++; $display("FAIL full_rw_dout got %h want 11", dout_a); end
    exp_seq = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hAA};
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++; if (dout_a !== exp_seq[i]) begin miscompares++; $display("FAIL full_rw_drain[%0d] got %h want %h", i, dout_a, exp_seq[i]); end
    end
    rd_a = 1'b0;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL full_rw_empty got %b want 1", empty_a); end
    wr_a = 1'b1; rd_a = 1'b1; din_a = 8'h33;
    step();
    wr_a = 1'b0; rd_a = 1'b0;
    vectors++; if (cnt_a !== 4'd1)   begin miscompares++; $display("FAIL empty_rw_count got %0d want 1", cnt_a); end
    vectors++; if (unf_a !== 1'b1)   begin miscompares++; $display("FAIL empty_rw_unf got %b want 1", unf_a); end
    vectors++; if (empty_a !== 1'b0) begin miscompares++; $display("FAIL empty_rw_empty got %b want 0", empty_a); end
    vectors++; if (dout_a !== 8'hAA) begin miscompares++; $display("FAIL empty_rw_dout got %h want aa", dout_a); end
    step();
    vectors++; if (unf_a !== 1'b0)   begin miscompares++; $display("FAIL empty_rw_unf_clear got %b want 0", unf_a); end
    rd_a = 1'b1;
    step();
    rd_a = 1'b0;
    vectors++; if (dout_a !== 8'h33) begin miscompares++; $display("FAIL empty_rw_read got %h want 33", dout_a); end
    vectors++; if (cnt_a !== 4'd0)   begin miscompares++; $display("FAIL empty_rw_final_count got %0d want 0", cnt_a); end
  endtask

  task automatic test_wrap_fwft();
    for (int i = 0; i < 12; i++) begin
      wr_b = 1'b1; din_b = 8'hC0 + 8'(i);
      step();
      wr_b = 1'b0;
      vectors++; if (empty_b !== 1'b0) begin miscompares++; $display("FAIL wrap_empty[%0d] got %b want 0", i, empty_b); end
      vectors++; if (dout_b !== 8'hC0 + 8'(i)) begin miscompares++; $display("FAIL wrap_data[%0d] got %h want %h", i, dout_b, 8'hC0 + 8'(i)); end
      rd_b = 1'b1;
      step();
      rd_b = 1'b0;
      vectors++; if (empty_b !== 1'b1 || cnt_b !== 3'd0) begin miscompares++; $display("FAIL wrap_pop[%0d] got empty=%b count=%0d want 1/0", i, empty_b, cnt_b); end
    end
    for (int i = 0; i < 5; i++) begin
      wr_b = 1'b1; din_b = 8'h80 + 8'(i);
      step();
    end
    wr_b = 1'b0;
    vectors++; if (full_b !== 1'b1 || cnt_b !== 3'd5) begin miscompares++; $display("FAIL burst_full got full=%b count=%0d want 1/5", full_b, cnt_b); end
    vectors++; if (af_b !== 1'b1) begin miscompares++; $display("FAIL burst_af got %b want 1", af_b); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (dout_b !== 8'h80 + 8'(i)) begin miscompares++; $display("FAIL burst_data[%0d] got %h want %h", i, dout_b, 8'h80 + 8'(i)); end
      rd_b = 1'b1;
      step();
      rd_b = 1'b0;
    end
    vectors++; if (empty_b !== 1'b1) begin miscompares++; $display("FAIL burst_empty got %b want 1", empty_b); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      wr_a = 1'b1; din_a = 8'h40 + 8'(i);
      step();
    end
    wr_a = 1'b0;
    vectors++; if (cnt_a !== 4'd4) begin miscompares++; $display("FAIL mid_pre_count got %0d want 4", cnt_a); end
    #3 rst = 1'b1;
    #1;
    vectors++; if (cnt_a !== 4'd0 || empty_a !== 1'b1) begin miscompares++; $display("FAIL mid_async count/empty got %0d/%b want 0/1", cnt_a, empty_a); end
    vectors++; if (ae_a !== 1'b1 || af_a !== 1'b0 || full_a !== 1'b0) begin miscompares++; $display("FAIL mid_async ae/af/full got %b/%b/%b want 1/0/0", ae_a, af_a, full_a); end
    vectors++; if (dout_a !== 8'h00) begin miscompares++; $display("FAIL mid_async_dout got %h want 00", dout_a); end
    wr_a = 1'b1; rd_a = 1'b1; din_a = 8'h99;
    step();
    step();
    vectors++; if (cnt_a !== 4'd0 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin miscompares++; $display("FAIL mid_held count/ovf/unf got %0d/%b/%b want 0/0/0", cnt_a, ovf_a, unf_a); end
    rst = 1'b0; rd_a = 1'b0; din_a = 8'h55;
    step();
    wr_a = 1'b0;
    vectors++; if (cnt_a !== 4'd1) begin miscompares++; $display("FAIL mid_release_count got %0d want 1", cnt_a); end
    rd_a = 1'b1;
    step();
    rd_a = 1'b0;
    vectors++; if (dout_a !== 8'h55) begin miscompares++; $display("FAIL mid_release_data got %h want 55", dout_a); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_wrap_fwft();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
